// File: rtl/mips_pkg.sv
// Shared decode constants and redirect encodings for the fetch sequencer.
// Imported by pc_sequencer; no configuration macros here.
package mips_pkg;

  localparam logic [5:0] OP_ALU = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_JAL = 6'd3;
  localparam logic [5:0] FN_JR  = 6'd8;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_J,
    SRC_JAL,
    SRC_JR
  } redir_src_e;

  typedef enum logic {
    ST_RUN,
    ST_PEND
  } seq_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full drops the oldest entry.
// Built only when PCSEQ_RAS_EN is defined.
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  input  logic [XLEN-1:0] pop_cmp_i,
  output logic [XLEN-1:0] top_o,
  output logic            mismatch_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx;
  logic [PW:0]     cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic            empty, full;

  assign top_idx = ptr_q - 1'b1;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);

  // pointer/count update; pop on empty leaves everything alone
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    mis_d = 1'b0;
    if (push_i) begin
      ptr_d = ptr_q + 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - 1'b1;
      mis_d = (mem_q[top_idx] != pop_cmp_i);
    end
  end

  // control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
    end
  end

  // entry storage, written at the current pointer
  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end

  assign top_o      = empty ? '0 : mem_q[top_idx];
  assign mismatch_o = mis_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: branch/jump redirect, stall capture, misalign flag.
// PCSEQ_RAS_EN adds a return-address stack and the ras_* ports.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            id_valid,
  input  logic [5:0]      id_op,
  input  logic [5:0]      id_funct,
  input  logic [25:0]     id_index,
  input  logic [XLEN-1:0] id_rs,
  input  logic [XLEN-1:0] id_pc,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_br_target,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush_if,
  output logic            misalign_err
`ifdef PCSEQ_RAS_EN
  ,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_mismatch
`endif
);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] ptgt_q, ptgt_d;
  logic            pmis_q, pmis_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;

  logic            is_j, is_jal, is_jr, id_mis;
  redir_src_e      id_src;
  logic [XLEN-1:0] pc4, link, jtgt, rtgt, id_tgt;

  assign is_j   = id_valid && (id_op == OP_J);
  assign is_jal = id_valid && (id_op == OP_JAL);
  assign is_jr  = id_valid && (id_op == OP_ALU)
               && (id_funct == FN_JR);
  assign id_mis = is_jr && (id_rs[1:0] != 2'b00);

  assign pc4  = pc_q + XLEN'(4);
  assign link = id_pc + XLEN'(4);
  assign jtgt = {link[XLEN-1:28], id_index, 2'b00};
  assign rtgt = {id_rs[XLEN-1:2], 2'b00};

  // classify the decode-stage instruction
  always_comb begin
    id_src = SRC_SEQ;
    unique case (1'b1)
      is_jal:  id_src = SRC_JAL;
      is_j:    id_src = SRC_J;
      is_jr:   id_src = SRC_JR;
      default: id_src = SRC_SEQ;
    endcase
  end

  assign id_tgt = (id_src == SRC_JR) ? rtgt : jtgt;

  // next PC, pending capture and one-cycle pulses
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = 1'b1;
    ptgt_d  = ptgt_q;
    pmis_d  = pmis_q;
    flush_d = 1'b0;
    mis_d   = 1'b0;
    if (valid_q) begin
      unique case (state_q)
        ST_RUN: begin
          if (stall) begin
            if (ex_br_taken) begin
              state_d = ST_PEND;
              ptgt_d  = ex_br_target;
              pmis_d  = 1'b0;
            end else if (id_src != SRC_SEQ) begin
              state_d = ST_PEND;
              ptgt_d  = id_tgt;
              pmis_d  = id_mis;
            end
          end else if (ex_br_taken) begin
            pc_d    = ex_br_target;
            flush_d = 1'b1;
          end else if (id_src != SRC_SEQ) begin
            pc_d    = id_tgt;
            flush_d = 1'b1;
            mis_d   = id_mis;
          end else begin
            pc_d = pc4;
          end
        end
        ST_PEND: begin
          if (stall) begin
            if (ex_br_taken) begin
              ptgt_d = ex_br_target;
              pmis_d = 1'b0;
            end
          end else begin
            state_d = ST_RUN;
            flush_d = 1'b1;
            if (ex_br_taken) begin
              pc_d = ex_br_target;
            end else begin
              pc_d  = ptgt_q;
              mis_d = pmis_q;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ptgt_q  <= '0;
      pmis_q  <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ptgt_q  <= ptgt_d;
      pmis_q  <= pmis_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = valid_q;
  assign flush_if     = flush_q;
  assign misalign_err = mis_q;

`ifdef PCSEQ_RAS_EN
  redir_src_e      psrc_q, psrc_d;
  logic [XLEN-1:0] plink_q, plink_d;
  logic            applied, push, pop;
  redir_src_e      app_src;
  logic [XLEN-1:0] app_tgt, app_link;

  // remember kind and link of a captured redirect
  always_comb begin
    psrc_d  = psrc_q;
    plink_d = plink_q;
    if (valid_q && stall) begin
      if (ex_br_taken) begin
        psrc_d = SRC_BR;
      end else if (state_q == ST_RUN
                   && id_src != SRC_SEQ) begin
        psrc_d  = id_src;
        plink_d = link;
      end
    end
  end

  // pending side-info registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psrc_q  <= SRC_SEQ;
      plink_q <= '0;
    end else begin
      psrc_q  <= psrc_d;
      plink_q <= plink_d;
    end
  end

  assign applied  = valid_q && !stall && !ex_br_taken;
  assign app_src  = (state_q == ST_PEND) ? psrc_q : id_src;
  assign app_tgt  = (state_q == ST_PEND) ? ptgt_q : id_tgt;
  assign app_link = (state_q == ST_PEND) ? plink_q : link;
  assign push     = applied && (app_src == SRC_JAL);
  assign pop      = applied && (app_src == SRC_JR);

  pc_ras #(
    .XLEN (XLEN),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .push_data_i(app_link),
    .pop_cmp_i  (app_tgt),
    .top_o      (ras_top),
    .mismatch_o (ras_mismatch)
  );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a behavioural model.
// Covers the PCSEQ_RAS_EN build too when the macro is defined.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        id_valid = 1'b0;
  logic [5:0]  id_op = '0;
  logic [5:0]  id_funct = '0;
  logic [25:0] id_index = '0;
  logic [31:0] id_rs = '0;
  logic [31:0] id_pc = '0;
  logic        ex_br_taken = 1'b0;
  logic [31:0] ex_br_target = '0;
  logic [31:0] pc;
  logic        pc_valid, flush_if, misalign_err;
`ifdef PCSEQ_RAS_EN
  logic [31:0] ras_top;
  logic        ras_mismatch;
`endif

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .id_valid    (id_valid),
    .id_op       (id_op),
    .id_funct    (id_funct),
    .id_index    (id_index),
    .id_rs       (id_rs),
    .id_pc       (id_pc),
    .ex_br_taken (ex_br_taken),
    .ex_br_target(ex_br_target),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .flush_if    (flush_if),
    .misalign_err(misalign_err)
`ifdef PCSEQ_RAS_EN
    ,
    .ras_top     (ras_top),
    .ras_mismatch(ras_mismatch)
`endif
  );

  // behavioural model state
  logic [31:0] m_pc;
  bit          m_valid, m_pend, m_flush, m_mis, m_rmis;
  logic [31:0] m_ptgt, m_plink;
  int          m_psrc;
  bit          m_pmis;
  logic [31:0] m_ras[$];
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;

  task automatic check(string nm, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // effects of an instruction actually redirecting the PC
  // kinds: 1 branch, 2 J, 3 JAL, 4 JR
  task automatic side(int k, logic [31:0] tgt,
                      logic [31:0] lnk, bit mis);
    logic [31:0] v;
    if (k == 3) begin
      if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
      m_ras.push_back(lnk);
    end
    if (k == 4) begin
      m_mis = mis;
      if (m_ras.size() > 0) begin
        v = m_ras.pop_back();
        m_rmis = (v != tgt);
      end
    end
  endtask

  task automatic model_step();
    int k;
    logic [31:0] lnk, jt;
    bit mis;
    lnk = id_pc + 32'd4;
    k = 0;
    if (id_valid) begin
      if (id_op == 6'd2) k = 2;
      else if (id_op == 6'd3) k = 3;
      else if (id_op == 6'd0 && id_funct == 6'd8) k = 4;
    end
    jt = (k == 4) ? (id_rs & ~32'h3)
                  : {lnk[31:28], id_index, 2'b00};
    mis = (k == 4) && (id_rs[1:0] != 2'b00);
    m_flush = 0;
    m_mis = 0;
    m_rmis = 0;
    if (!rst_n) begin
      m_pc = 32'h0;
      m_valid = 0;
      m_pend = 0;
      m_ras.delete();
    end else if (!m_valid) begin
      m_valid = 1;
    end else if (stall) begin
      if (ex_br_taken) begin
        m_pend = 1;
        m_ptgt = ex_br_target;
        m_psrc = 1;
        m_pmis = 0;
      end else if (!m_pend && k != 0) begin
        m_pend = 1;
        m_ptgt = jt;
        m_psrc = k;
        m_plink = lnk;
        m_pmis = mis;
      end
    end else if (m_pend) begin
      m_pend = 0;
      m_flush = 1;
      if (ex_br_taken) m_pc = ex_br_target;
      else begin
        m_pc = m_ptgt;
        side(m_psrc, m_ptgt, m_plink, m_pmis);
      end
    end else if (ex_br_taken) begin
      m_pc = ex_br_target;
      m_flush = 1;
    end else if (k != 0) begin
      m_pc = jt;
      m_flush = 1;
      side(k, jt, lnk, mis);
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic idle();
    stall = 0;
    id_valid = 0;
    id_op = '0;
    id_funct = '0;
    ex_br_taken = 0;
  endtask

  task automatic jinst(logic [5:0] op, logic [31:0] ipc,
                       logic [25:0] idx, logic [31:0] rs);
    id_valid = 1;
    id_op = op;
    id_funct = 6'd8;
    id_pc = ipc;
    id_index = idx;
    id_rs = rs;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("pc_valid", 32'(pc_valid), 32'(m_valid));
      check("flush_if", 32'(flush_if), 32'(m_flush));
      check("misalign", 32'(misalign_err), 32'(m_mis));
`ifdef PCSEQ_RAS_EN
      check("ras_top", ras_top,
            (m_ras.size() > 0) ? m_ras[$] : 32'h0);
      check("ras_mis", 32'(ras_mismatch), 32'(m_rmis));
`endif
    end
  end

  initial begin
    rst_n = 0;
    cyc();
    cyc();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", 32'(pc_valid), 32'h0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("seq_pc", pc, 32'(i * 4));
      check("seq_valid", 32'(pc_valid), 32'h1);
    end
    // J
    jinst(6'd2, 32'h0040_0010, 26'h10, 32'h0);
    cyc();
    idle();
    check("j_pc", pc, 32'h40);
    check("j_flush", 32'(flush_if), 32'h1);
    check("j_model", m_pc, 32'h40);
    cyc();
    check("j_flush_end", 32'(flush_if), 32'h0);
    check("j_pc4", pc, 32'h44);
    // stalled JR, overwritten by branch
    stall = 1;
    jinst(6'd0, 32'h0, 26'h0, 32'h100);
    cyc();
    check("st_hold1", pc, 32'h44);
    id_valid = 0;
    ex_br_taken = 1;
    ex_br_target = 32'h200;
    cyc();
    check("st_hold2", pc, 32'h44);
    check("st_noflush", 32'(flush_if), 32'h0);
    ex_br_taken = 0;
    cyc();
    check("st_hold3", pc, 32'h44);
    stall = 0;
    cyc();
    check("st_rel_pc", pc, 32'h200);
    check("st_rel_flush", 32'(flush_if), 32'h1);
    cyc();
    check("st_flush_end", 32'(flush_if), 32'h0);
    check("st_pc4", pc, 32'h204);
    // branch beats JAL
    jinst(6'd3, 32'h5000, 26'h123, 32'h0);
    ex_br_taken = 1;
    ex_br_target = 32'h300;
    cyc();
    idle();
    check("br_jal_pc", pc, 32'h300);
`ifdef PCSEQ_RAS_EN
    check("br_jal_ras", ras_top, 32'h0);
`endif
    // misaligned JR
    jinst(6'd0, 32'h0, 26'h0, 32'h1002);
    cyc();
    idle();
    check("jr_pc", pc, 32'h1000);
    check("jr_mis", 32'(misalign_err), 32'h1);
    cyc();
    check("jr_mis_end", 32'(misalign_err), 32'h0);
    // 5 calls then 5 returns
    for (int i = 1; i <= 5; i++) begin
      jinst(6'd3, 32'(i * 256), 26'h40, 32'h0);
      cyc();
      idle();
      check("call_pc", pc, 32'h100);
    end
    for (int i = 5; i >= 1; i--) begin
      jinst(6'd0, 32'h0, 26'h0, 32'(i * 256 + 4));
      cyc();
      idle();
      check("ret_pc", pc, 32'(i * 256 + 4));
`ifdef PCSEQ_RAS_EN
      check("ret_mis", 32'(ras_mismatch), 32'h0);
      check("ret_top", ras_top,
            (i > 2) ? 32'((i - 1) * 256 + 4) : 32'h0);
`endif
    end
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      rst_n = ($urandom_range(0, 199) != 0);
      stall = ($urandom_range(0, 3) == 0);
      id_valid = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 7);
      if (r < 2) id_op = 6'd0;
      else if (r < 4) id_op = 6'd2;
      else if (r < 6) id_op = 6'd3;
      else id_op = 6'($urandom);
      id_funct = ($urandom_range(0, 3) != 0)
               ? 6'd8 : 6'($urandom);
      id_index = 26'($urandom);
      id_rs = $urandom;
      if ($urandom_range(0, 1) == 1) id_rs[1:0] = 2'b00;
      id_pc = $urandom & 32'hFFFF_FFFC;
      ex_br_taken = ($urandom_range(0, 6) == 0);
      ex_br_target = $urandom & 32'hFFFF_FFFC;
      cyc();
    end
    idle();
    rst_n = 1;
    cyc();
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
